page_table_walker: RTL and testbench

Two-level 386 page-table walker sitting between the address-generation path and the bus interface. It consumes `PG` and `page_directory_base` from the control register file, fetches the PDE and PTE through a single-outstanding memory read port, checks present/protection bits and returns a physical address or a page fault. On a fault it writes the faulting linear address into CR2 through the control register write port. It has no TLB and does not update Accessed/Dirty bits.

---
 rtl/page_table_walker.sv | 202 ++++++++++++++++++++
 tb/tb_page_table_walker.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/page_table_walker.sv
`default_nettype none
// ============================================================================
//  Module      : page_table_walker
//  Description : Two-level 386 page-table walker. Fetches PDE and PTE over a
//                single-outstanding read port, checks present and user/write
//                protection, and returns a physical address or a page fault.
//                A fault also writes the faulting linear address into CR2.
//  Revision    : 1.0 - initial release
// ============================================================================
module page_table_walker (
  input  logic        clock,
  input  logic        reset,
  input  logic        PG,
  input  logic [19:0] page_directory_base,
  input  logic        request_valid,
  output logic        request_ready,
  input  logic [31:0] request_linear_address,
  input  logic        request_write,
  input  logic        request_user,
  output logic        memory_read_valid,
  input  logic        memory_read_ready,
  output logic [31:0] memory_read_address,
  input  logic        memory_data_valid,
  input  logic [31:0] memory_data,
  output logic        response_valid,
  input  logic        response_ready,
  output logic [31:0] response_physical_address,
  output logic        response_fault,
  output logic [2:0]  response_error_code,
  output logic        cr_write_enable,
  output logic [2:0]  cr_write_index,
  output logic [31:0] cr_write_data
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PDE_REQ  = 3'd1,
    PDE_WAIT = 3'd2,
    PTE_REQ  = 3'd3,
    PTE_WAIT = 3'd4,
    RESPOND  = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] lin_q, lin_d;
  logic        write_q, write_d;
  logic        user_q, user_d;
  logic [19:0] pdb_q, pdb_d;
  logic [19:0] pde_base_q, pde_base_d;
  logic        pde_user_q, pde_user_d;
  logic        pde_rw_q, pde_rw_d;
  logic [31:0] phys_q, phys_d;
  logic        fault_q, fault_d;
  logic [2:0]  err_q, err_d;
  logic        cr_we_q, cr_we_d;

  logic        take_fault;
  logic        fault_present;
  logic        eff_user;
  logic        eff_rw;

  // Entry bits between the present/RW/US flags and the frame number carry
  // Accessed/Dirty/AVL information this walker never consumes.
  logic        unused_entry_bits;
  assign unused_entry_bits = ^memory_data[11:3];

  // Combined user/write permission of the PDE already latched and the PTE on the bus.
  assign eff_user = pde_user_q & memory_data[2];
  assign eff_rw   = pde_rw_q   & memory_data[1];

  // Next-state and datapath updates for the walk.
  always_comb begin
    state_d       = state_q;
    lin_d         = lin_q;
    write_d       = write_q;
    user_d        = user_q;
    pdb_d         = pdb_q;
    pde_base_d    = pde_base_q;
    pde_user_d    = pde_user_q;
    pde_rw_d      = pde_rw_q;
    phys_d        = phys_q;
    fault_d       = fault_q;
    err_d         = err_q;
    cr_we_d       = 1'b0;
    take_fault    = 1'b0;
    fault_present = 1'b0;

    case (state_q)
      IDLE: begin
        if (request_valid) begin
          lin_d   = request_linear_address;
          write_d = request_write;
          user_d  = request_user;
          pdb_d   = page_directory_base;
          if (PG) begin
            state_d = PDE_REQ;
          end else begin
            phys_d  = request_linear_address;
            fault_d = 1'b0;
            err_d   = 3'd0;
            state_d = RESPOND;
          end
        end
      end
      PDE_REQ: begin
        if (memory_read_ready) state_d = PDE_WAIT;
      end
      PDE_WAIT: begin
        if (memory_data_valid) begin
          if (!memory_data[0]) begin
            take_fault = 1'b1;
          end else begin
            pde_base_d = memory_data[31:12];
            pde_user_d = memory_data[2];
            pde_rw_d   = memory_data[1];
            state_d    = PTE_REQ;
          end
        end
      end
      PTE_REQ: begin
        if (memory_read_ready) state_d = PTE_WAIT;
      end
      PTE_WAIT: begin
        if (memory_data_valid) begin
          if (!memory_data[0]) begin
            take_fault = 1'b1;
          end else if (user_q && (!eff_user || (write_q && !eff_rw))) begin
            take_fault    = 1'b1;
            fault_present = 1'b1;
          end else begin
            phys_d  = {memory_data[31:12], lin_q[11:0]};
            fault_d = 1'b0;
            err_d   = 3'd0;
            state_d = RESPOND;
          end
        end
      end
      RESPOND: begin
        if (response_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Common fault exit: error code, zero address and a one-shot CR2 write.
    if (take_fault) begin
      phys_d  = 32'd0;
      fault_d = 1'b1;
      err_d   = {user_q, write_q, fault_present};
      cr_we_d = 1'b1;
      state_d = RESPOND;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      lin_q      <= 32'd0;
      write_q    <= 1'b0;
      user_q     <= 1'b0;
      pdb_q      <= 20'd0;
      pde_base_q <= 20'd0;
      pde_user_q <= 1'b0;
      pde_rw_q   <= 1'b0;
      phys_q     <= 32'd0;
      fault_q    <= 1'b0;
      err_q      <= 3'd0;
      cr_we_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      lin_q      <= lin_d;
      write_q    <= write_d;
      user_q     <= user_d;
      pdb_q      <= pdb_d;
      pde_base_q <= pde_base_d;
      pde_user_q <= pde_user_d;
      pde_rw_q   <= pde_rw_d;
      phys_q     <= phys_d;
      fault_q    <= fault_d;
      err_q      <= err_d;
      cr_we_q    <= cr_we_d;
    end
  end

  // Output decode: fields are forced to zero whenever their valid is low.
  always_comb begin
    request_ready             = (state_q == IDLE);
    memory_read_valid         = (state_q == PDE_REQ) || (state_q == PTE_REQ);
    memory_read_address       = 32'd0;
    if (state_q == PDE_REQ) memory_read_address = {pdb_q, lin_q[31:22], 2'b00};
    if (state_q == PTE_REQ) memory_read_address = {pde_base_q, lin_q[21:12], 2'b00};
    response_valid            = (state_q == RESPOND);
    response_physical_address = response_valid ? phys_q : 32'd0;
    response_fault            = response_valid & fault_q;
    response_error_code       = response_valid ? err_q : 3'd0;
    cr_write_enable           = cr_we_q;
    cr_write_index            = cr_we_q ? 3'd2 : 3'd0;
    cr_write_data             = cr_we_q ? lin_q : 32'd0;
  end

endmodule
`default_nettype wire

// File: tb/tb_page_table_walker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_page_table_walker
//  Description : Self-checking bench for page_table_walker with a behavioural
//                translation model, a reactive memory responder and a
//                per-cycle compare process.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_page_table_walker;

  logic        clock = 1'b0;
  logic        reset;
  logic        PG;
  logic [19:0] page_directory_base;
  logic        request_valid;
  logic        request_ready;
  logic [31:0] request_linear_address;
  logic        request_write;
  logic        request_user;
  logic        memory_read_valid;
  logic        memory_read_ready;
  logic [31:0] memory_read_address;
  logic        memory_data_valid;
  logic [31:0] memory_data;
  logic        response_valid;
  logic        response_ready;
  logic [31:0] response_physical_address;
  logic        response_fault;
  logic [2:0]  response_error_code;
  logic        cr_write_enable;
  logic [2:0]  cr_write_index;
  logic [31:0] cr_write_data;

  page_table_walker dut (
    .clock                     (clock),
    .reset                     (reset),
    .PG                        (PG),
    .page_directory_base       (page_directory_base),
    .request_valid             (request_valid),
    .request_ready             (request_ready),
    .request_linear_address    (request_linear_address),
    .request_write             (request_write),
    .request_user              (request_user),
    .memory_read_valid         (memory_read_valid),
    .memory_read_ready         (memory_read_ready),
    .memory_read_address       (memory_read_address),
    .memory_data_valid         (memory_data_valid),
    .memory_data               (memory_data),
    .response_valid            (response_valid),
    .response_ready            (response_ready),
    .response_physical_address (response_physical_address),
    .response_fault            (response_fault),
    .response_error_code       (response_error_code),
    .cr_write_enable           (cr_write_enable),
    .cr_write_index            (cr_write_index),
    .cr_write_data             (cr_write_data)
  );

  always #5 clock = ~clock;

  // Scoreboard state
  int          vectors = 0;
  int          misc = 0;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] exp_reads [$];
  logic [31:0] exp_phys;
  logic [31:0] exp_lin;
  logic        exp_fault;
  logic [2:0]  exp_err;
  logic        exp_active = 1'b0;
  int          base_lat;
  int          inj_waits = 0;
  int          w_override = -1;
  bit          rand_delays = 1'b0;
  bit          auto_mem = 1'b1;
  int          reads_seen = 0;
  int          cr_seen = 0;
  int          resp_seen = 0;
  logic        prev_rv = 1'b0;
  logic        exp_cr;

  // Driver scratch
  logic [31:0] obs_phys;
  logic        obs_fault;
  logic [2:0]  obs_err;
  int          obs_lat;
  int          r0, c0, s0;
  logic [31:0] t_lin, t_pde, t_pte;
  logic [19:0] t_pdb;
  logic        t_pg, t_wr, t_us;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      misc++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic finish_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
    $finish;
  endtask

  task automatic wait_cycle();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'd0;
  endfunction

  // Reference translation: what a 386 two-level walk must produce.
  task automatic model_walk(input logic [31:0] lin, input logic wr, input logic us,
                            input logic pg, input logic [19:0] pdb);
    logic [31:0] pde, pte, pa;
    logic        u, rw, p;
    exp_reads.delete();
    exp_lin   = lin;
    exp_fault = 1'b0;
    exp_err   = 3'd0;
    exp_phys  = lin;
    base_lat  = 1;
    if (!pg) return;
    pa = {pdb, lin[31:22], 2'b00};
    exp_reads.push_back(pa);
    pde = mem_read(pa);
    base_lat = 3;
    p = 1'b0;
    if (pde[0]) begin
      pa = {pde[31:12], lin[21:12], 2'b00};
      exp_reads.push_back(pa);
      pte = mem_read(pa);
      base_lat = 5;
      if (pte[0]) begin
        u  = pde[2] & pte[2];
        rw = pde[1] & pte[1];
        p  = 1'b1;
        if (!(us && (!u || (wr && !rw)))) begin
          exp_phys = {pte[31:12], lin[11:0]};
          return;
        end
      end
    end
    exp_fault = 1'b1;
    exp_err   = {us, wr, p};
    exp_phys  = 32'd0;
  endtask

  // One complete request/response transaction with latency measurement.
  task automatic do_txn(input logic [31:0] lin, input logic wr, input logic us,
                        input logic pg, input logic [19:0] pdb, input int hold,
                        output logic [31:0] ph, output logic f, output logic [2:0] e,
                        output int lat);
    model_walk(lin, wr, us, pg, pdb);
    PG = pg;
    page_directory_base = pdb;
    request_linear_address = lin;
    request_write = wr;
    request_user = us;
    request_valid = 1'b1;
    inj_waits = 0;
    wait_cycle();
    exp_active = 1'b1;
    request_valid = 1'b0;
    PG = 1'($urandom);
    page_directory_base = 20'($urandom);
    request_linear_address = $urandom;
    request_write = 1'($urandom);
    request_user = 1'($urandom);
    lat = 1;
    while (!response_valid) begin
      if (lat >= 100) begin
        check("response_timeout", 32'(response_valid), 32'd1);
        finish_run();
      end
      wait_cycle();
      lat++;
    end
    ph = response_physical_address;
    f  = response_fault;
    e  = response_error_code;
    check("latency", lat, base_lat + inj_waits);
    repeat (hold) wait_cycle();
    response_ready = 1'b1;
    wait_cycle();
    response_ready = 1'b0;
    exp_active = 1'b0;
  endtask

  // Reactive memory: random ready/data delays, garbage beats while not waiting.
  initial begin : memory_responder
    int          w, d;
    logic [31:0] a;
    memory_read_ready = 1'b0;
    memory_data_valid = 1'b0;
    memory_data = 32'd0;
    forever begin
      if (auto_mem && !reset && memory_read_valid) begin
        if (w_override >= 0) begin
          w = w_override;
          w_override = -1;
        end else begin
          w = rand_delays ? int'($urandom_range(0, 2)) : 0;
        end
        repeat (w) begin
          memory_read_ready = 1'b0;
          memory_data_valid = rand_delays ? 1'($urandom) : 1'b0;
          memory_data = $urandom;
          wait_cycle();
        end
        memory_read_ready = 1'b1;
        memory_data_valid = 1'b0;
        a = memory_read_address;
        wait_cycle();
        memory_read_ready = 1'b0;
        d = rand_delays ? int'($urandom_range(0, 2)) : 0;
        inj_waits += w + d;
        repeat (d) wait_cycle();
        memory_data_valid = 1'b1;
        memory_data = mem_read(a);
        wait_cycle();
        memory_data_valid = 1'b0;
      end else begin
        wait_cycle();
      end
    end
  end

  // Per-cycle compare of every meaningful output against the model.
  initial begin : compare_process
    forever begin
      @(negedge clock);
      if (reset) begin
        prev_rv = 1'b0;
      end else begin
        check("request_ready", 32'(request_ready), 32'(!exp_active));
        if (response_valid) begin
          if (!exp_active) begin
            check("unexpected_response", 32'(response_valid), 32'd0);
          end else begin
            check("resp_phys", response_physical_address, exp_phys);
            check("resp_fault", 32'(response_fault), 32'(exp_fault));
            check("resp_err", 32'(response_error_code), 32'(exp_err));
          end
          if (!prev_rv) resp_seen++;
        end
        exp_cr = response_valid && !prev_rv && exp_active && exp_fault;
        check("cr_write_enable", 32'(cr_write_enable), 32'(exp_cr));
        if (cr_write_enable) begin
          cr_seen++;
          check("cr_write_index", 32'(cr_write_index), 32'd2);
          check("cr_write_data", cr_write_data, exp_lin);
        end
        if (memory_read_valid) begin
          if (exp_reads.size() == 0) begin
            check("unexpected_read", 32'(memory_read_valid), 32'd0);
          end else begin
            check("read_address", memory_read_address, exp_reads[0]);
            if (memory_read_ready) begin
              void'(exp_reads.pop_front());
              reads_seen++;
            end
          end
        end
        prev_rv = response_valid;
      end
    end
  end

  initial begin : main
    reset = 1'b1;
    PG = 1'b0;
    page_directory_base = 20'd0;
    request_valid = 1'b0;
    request_linear_address = 32'd0;
    request_write = 1'b0;
    request_user = 1'b0;
    response_ready = 1'b0;
    repeat (3) wait_cycle();

    check("rst_request_ready", 32'(request_ready), 32'd1);
    check("rst_response_valid", 32'(response_valid), 32'd0);
    check("rst_read_valid", 32'(memory_read_valid), 32'd0);
    check("rst_read_address", memory_read_address, 32'd0);
    check("rst_cr_we", 32'(cr_write_enable), 32'd0);
    check("rst_cr_data", cr_write_data, 32'd0);
    check("rst_phys", response_physical_address, 32'd0);
    check("rst_err", 32'(response_error_code), 32'd0);
    reset = 1'b0;
    wait_cycle();

    // Paging disabled: identity, one cycle, no memory traffic.
    r0 = reads_seen; c0 = cr_seen;
    do_txn(32'h1234_5678, 1'b0, 1'b0, 1'b0, 20'h0, 1, obs_phys, obs_fault, obs_err, obs_lat);
    check("pg0_phys", obs_phys, 32'h1234_5678);
    check("pg0_fault", 32'(obs_fault), 32'd0);
    check("pg0_latency", obs_lat, 1);
    check("pg0_reads", reads_seen - r0, 0);
    check("pg0_cr", cr_seen - c0, 0);

    // Successful two-level walk, zero wait states.
    mem.delete();
    mem[32'h0001_0004] = 32'h0002_0007;
    mem[32'h0002_000C] = 32'h0055_5007;
    r0 = reads_seen;
    do_txn(32'h0040_3ABC, 1'b0, 1'b0, 1'b1, 20'h00010, 0, obs_phys, obs_fault, obs_err, obs_lat);
    check("walk_phys", obs_phys, 32'h0055_5ABC);
    check("walk_fault", 32'(obs_fault), 32'd0);
    check("walk_latency", obs_lat, 5);
    check("walk_reads", reads_seen - r0, 2);

    // Not-present PDE, user read.
    mem[32'h0001_0004] = 32'h0002_0006;
    r0 = reads_seen; c0 = cr_seen;
    do_txn(32'h0040_3ABC, 1'b0, 1'b1, 1'b1, 20'h00010, 0, obs_phys, obs_fault, obs_err, obs_lat);
    check("np_fault", 32'(obs_fault), 32'd1);
    check("np_err", 32'(obs_err), 32'd4);
    check("np_phys", obs_phys, 32'd0);
    check("np_latency", obs_lat, 3);
    check("np_reads", reads_seen - r0, 1);
    check("np_cr_writes", cr_seen - c0, 1);

    // Read-only PTE: user write faults, supervisor write succeeds.
    mem[32'h0001_0004] = 32'h0002_0007;
    mem[32'h0002_000C] = 32'h0055_5005;
    do_txn(32'h0040_3ABC, 1'b1, 1'b1, 1'b1, 20'h00010, 0, obs_phys, obs_fault, obs_err, obs_lat);
    check("ro_user_fault", 32'(obs_fault), 32'd1);
    check("ro_user_err", 32'(obs_err), 32'd7);
    do_txn(32'h0040_3ABC, 1'b1, 1'b0, 1'b1, 20'h00010, 0, obs_phys, obs_fault, obs_err, obs_lat);
    check("ro_super_fault", 32'(obs_fault), 32'd0);
    check("ro_super_phys", obs_phys, 32'h0055_5ABC);

    // Backpressure: ready held low 3 cycles on the PDE read, response held 4 cycles.
    mem[32'h0002_000C] = 32'h0055_5007;
    w_override = 3;
    do_txn(32'h0040_3ABC, 1'b0, 1'b0, 1'b1, 20'h00010, 4, obs_phys, obs_fault, obs_err, obs_lat);
    check("bp_latency", obs_lat, 8);
    check("bp_phys", obs_phys, 32'h0055_5ABC);

    // Reset while waiting for the PTE: walk aborted, late beat ignored.
    auto_mem = 1'b0;
    s0 = resp_seen; c0 = cr_seen;
    model_walk(32'h0040_3ABC, 1'b1, 1'b1, 1'b1, 20'h00010);
    PG = 1'b1;
    page_directory_base = 20'h00010;
    request_linear_address = 32'h0040_3ABC;
    request_write = 1'b1;
    request_user = 1'b1;
    request_valid = 1'b1;
    wait_cycle();
    exp_active = 1'b1;
    request_valid = 1'b0;
    check("abort_pde_valid", 32'(memory_read_valid), 32'd1);
    memory_read_ready = 1'b1;
    wait_cycle();
    memory_read_ready = 1'b0;
    memory_data_valid = 1'b1;
    memory_data = 32'h0002_0007;
    wait_cycle();
    memory_data_valid = 1'b0;
    check("abort_pte_valid", 32'(memory_read_valid), 32'd1);
    memory_read_ready = 1'b1;
    wait_cycle();
    memory_read_ready = 1'b0;
    reset = 1'b1;
    wait_cycle();
    reset = 1'b0;
    exp_active = 1'b0;
    exp_reads.delete();
    check("abort_request_ready", 32'(request_ready), 32'd1);
    memory_data_valid = 1'b1;
    memory_data = 32'h0055_5007;
    wait_cycle();
    memory_data_valid = 1'b0;
    repeat (5) wait_cycle();
    check("abort_no_response", resp_seen - s0, 0);
    check("abort_no_cr", cr_seen - c0, 0);
    check("abort_idle_ready", 32'(request_ready), 32'd1);
    auto_mem = 1'b1;

    // Randomized walks with random bus and consumer delays.
    rand_delays = 1'b1;
    for (int i = 0; i < 300; i++) begin
      t_lin = $urandom;
      t_pdb = 20'($urandom);
      t_pg  = ($urandom_range(0, 3) != 0);
      t_wr  = 1'($urandom);
      t_us  = 1'($urandom);
      t_pde = $urandom;
      t_pde[0] = ($urandom_range(0, 7) != 0);
      t_pte = $urandom;
      t_pte[0] = ($urandom_range(0, 7) != 0);
      mem.delete();
      mem[{t_pdb, t_lin[31:22], 2'b00}] = t_pde;
      mem[{t_pde[31:12], t_lin[21:12], 2'b00}] = t_pte;
      repeat ($urandom_range(0, 2)) wait_cycle();
      do_txn(t_lin, t_wr, t_us, t_pg, t_pdb, int'($urandom_range(0, 3)),
             obs_phys, obs_fault, obs_err, obs_lat);
    end

    repeat (3) wait_cycle();
    finish_run();
  end

endmodule
`default_nettype wire
